dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported, multi-cycle data memory. It shares the memory between the CPU MEM stage (port `cpu`) and a debug/loader port (port `dbg`), drives the memory strobes for a fixed access latency, and returns a one-cycle acknowledge with read data. It also generates the pipeline stall signal that freezes the CPU while a MEM-stage access is outstanding. It sits between the MEM stage / debug loader and `DataMemory`.

## Interface
- `LATENCY`, 2: memory access cycles per transaction; legal range is ≥1, and 0 is illegal.
- `STARVE_MAX`, 4: consecutive contested CPU grants after which `dbg` wins the next contested arbitration.
- `ADDR_W`, 32: address width.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `cpu_req_i`  in  1  CPU access request (level, held until ack).
- `cpu_we_i`  in  1  CPU write (1) / read (0).
- `cpu_addr_i`  in  ADDR_W  CPU byte address.
- `cpu_wdata_i`  in  32  CPU write data.
- `cpu_rdata_o`  out  32  CPU read data; registered, valid with ack, held until the next CPU completion.
- `cpu_ack_o`  out  1  one-cycle completion pulse.
- `cpu_stall_o`  out  1  equals `cpu_req_i & ~cpu_ack_o` (combinational).
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`, `dbg_rdata_o`, `dbg_ack_o`: same as the `cpu` signals, for the debug port.
- `mem_en_o`  out  1  memory enable.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  memory read data; valid in the last BUSY cycle.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE:**
  - With no request, the state stays IDLE.
  - With a request, the arbiter latches the owner, `we`, `addr` and `wdata`, loads `cnt = LATENCY-1`, and moves to BUSY.
- **Arbitration (IDLE only):**
  - With a single requester, that requester wins.
  - With both requesting, `cpu` wins unless `starve_cnt == STARVE_MAX`, in which case `dbg` wins.
- **starve_cnt:**
  - Increments (saturating at STARVE_MAX) on a CPU grant made while `dbg_req_i = 1`.
  - Clears on any `dbg` grant.
  - Clears on any IDLE cycle with `dbg_req_i = 0`.
- **BUSY:**
  - Drives `mem_en_o = 1`, `mem_we_o` = latched `we`, and the latched address and data. All `mem_*` outputs are 0 outside BUSY.
  - `cnt` decrements every edge.
  - On the edge where `cnt == 0`, `mem_rdata_i` is captured into the owner's rdata register (reads only; rdata is unchanged on writes), and the state moves to DONE.
- **DONE:**
  - The owner's ack is 1 for exactly this cycle; the state returns to IDLE next edge.
  - Requests are not arbitrated in DONE. A request still high in the following IDLE cycle is treated as a new transaction.
- **Protocol violations:**
  - If a request drops mid-BUSY, the transaction completes anyway and ack still pulses.
  - Request-side inputs are ignored after the IDLE latch edge.
- Addresses pass through unmodified. Byte lane and alignment handling belong to the memory.

## Timing
- **Reset:** asynchronous. It forces IDLE, `cnt = 0`, `starve_cnt = 0`, both rdata registers = 0, and all acks, `mem_*` outputs and `busy_o` = 0.
  - Reset mid-BUSY drops `mem_en_o`/`mem_we_o` immediately, with no ack.
  - `cpu_stall_o` follows `cpu_req_i` during reset.
- **Latency:** request sampled high at the end of cycle C gives:
  - BUSY in cycles C+1 through C+LATENCY;
  - ack and rdata valid in cycle C+LATENCY+1;
  - earliest next latch at the end of C+LATENCY+2.
- **Throughput:** one access per LATENCY+2 cycles.
- **Stall:** `cpu_stall_o` is high from the first request cycle through the last BUSY cycle, and low in DONE. The pipeline advances on the edge ending DONE.
- **Simultaneous events:**
  - A `dbg` request arriving during a CPU BUSY waits; it is arbitrated in the next IDLE.
  - Both ports requesting back-to-back alternate as cpu×STARVE_MAX then dbg.

## Test plan
- **Reset:** assert `rst_i` mid-BUSY of a write (addr 0x10, data 0xDEADBEEF), asynchronously between edges -> `mem_en_o`/`mem_we_o` drop the same delta; `busy_o = 0`; no ack; rdata = 0.
- **CPU read, LATENCY=2:** memory returns 0x5 for addr 0x00; request in cycle 0 -> BUSY in cycles 1–2, `cpu_ack_o = 1` in cycle 3 only, `cpu_rdata_o = 5`; `cpu_stall_o` high in cycles 0–2, low in cycle 3.
- **dbg write:** dbg write of 0x12345678 to 0x04, then CPU read of 0x04 -> `mem_we_o` high for exactly 2 cycles; the CPU later reads 0x12345678; `cpu_rdata_o` is unchanged by the dbg write.
- **Contention/starvation, STARVE_MAX=4:** both ports hold requests continuously -> grant order cpu, cpu, cpu, cpu, dbg, then repeating; never five consecutive contested CPU grants.
- **Back-to-back and violation:**
  - CPU holds `cpu_req_i` through DONE -> second access starts at the end of the IDLE cycle; ack spacing is 4 cycles.
  - Drop the request mid-BUSY -> ack still pulses once.
- **LATENCY=1:** single BUSY cycle; ack 2 cycles after the request cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported multi-cycle data memory between the CPU MEM stage and a debug port,
// sequencing each access over LATENCY busy cycles and returning a one-cycle ack with registered read data.
module dmem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;
    logic          owner;
    logic          starved;
    logic          dbg_win;

    assign starved     = starve_cnt == SW'(STARVE_MAX);
    assign dbg_win     = dbg_req_i & (~cpu_req_i | starved);
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

    // owner: 1 = dbg holds the current transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            starve_cnt  <= '0;
            owner       <= 1'b0;
            cpu_rdata_o <= '0;
            dbg_rdata_o <= '0;
            cpu_ack_o   <= 1'b0;
            dbg_ack_o   <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // a dbg-pending cycle that does not grant dbg is necessarily a contested cpu grant
                    starve_cnt <= (!dbg_req_i || dbg_win) ? '0 : starve_cnt + 1'b1;
                    if (cpu_req_i || dbg_req_i) begin
                        state       <= BUSY;
                        busy_o      <= 1'b1;
                        owner       <= dbg_win;
                        cnt         <= CW'(LATENCY - 1);
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= dbg_win ? dbg_we_i : cpu_we_i;
                        mem_addr_o  <= dbg_win ? dbg_addr_i : cpu_addr_i;
                        mem_wdata_o <= dbg_win ? dbg_wdata_i : cpu_wdata_i;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state       <= DONE;
                        mem_en_o    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        cpu_ack_o   <= ~owner;
                        dbg_ack_o   <= owner;
                        if (!mem_we_o && owner)  dbg_rdata_o <= mem_rdata_i;
                        if (!mem_we_o && !owner) cpu_rdata_o <= mem_rdata_i;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    cpu_ack_o <= 1'b0;
                    dbg_ack_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench for dmem_arbiter (LATENCY=2) plus a LATENCY=1 instance.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        c_ack, c_stall, d_ack, m_en, m_we, busy;
    logic        r1 = 1'b0;
    logic [31:0] a1 = '0;
    logic [31:0] rd1, drd1, ma1, mwd1, mrd1;
    logic        ack1, stall1, dack1, en1, we1, busy1;
    logic [31:0] mem [16];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.LATENCY(2), .STARVE_MAX(4), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(c_req), .cpu_we_i(c_we), .cpu_addr_i(c_addr), .cpu_wdata_i(c_wdata),
        .cpu_rdata_o(c_rdata), .cpu_ack_o(c_ack), .cpu_stall_o(c_stall),
        .dbg_req_i(d_req), .dbg_we_i(d_we), .dbg_addr_i(d_addr), .dbg_wdata_i(d_wdata),
        .dbg_rdata_o(d_rdata), .dbg_ack_o(d_ack),
        .mem_en_o(m_en), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
        .mem_rdata_i(m_rdata), .busy_o(busy)
    );

    dmem_arbiter #(.LATENCY(1), .STARVE_MAX(4), .ADDR_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(r1), .cpu_we_i(1'b0), .cpu_addr_i(a1), .cpu_wdata_i(32'h0),
        .cpu_rdata_o(rd1), .cpu_ack_o(ack1), .cpu_stall_o(stall1),
        .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'h0), .dbg_wdata_i(32'h0),
        .dbg_rdata_o(drd1), .dbg_ack_o(dack1),
        .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(ma1), .mem_wdata_o(mwd1),
        .mem_rdata_i(mrd1), .busy_o(busy1)
    );

    // memory model: combinational read, write on each busy edge; word 0 preloaded with 5
    assign m_rdata = mem[m_addr[5:2]];
    assign mrd1    = mem[ma1[5:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'd5 : 32'd0;
        end else if (m_en && m_we) begin
            mem[m_addr[5:2]] <= m_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // req = {cpu_req, cpu_we, dbg_req, dbg_we}; flg = {busy, mem_en, mem_we, cpu_ack, dbg_ack, cpu_stall}
    typedef struct {
        logic [3:0]  req;
        logic [31:0] ca, cd, da, dd;
        logic [5:0]  flg;
        logic [31:0] maddr, crd, drd;
    } vec_t;

    function automatic vec_t v(input logic [3:0] req, input logic [31:0] ca, cd, da, dd,
                               input logic [5:0] flg, input logic [31:0] maddr, crd, drd);
        vec_t t;
        t.req = req; t.ca = ca; t.cd = cd; t.da = da; t.dd = dd;
        t.flg = flg; t.maddr = maddr; t.crd = crd; t.drd = drd;
        return t;
    endfunction

    vec_t tbl [23];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int grants [10];
        int ng, at [2];
        logic [9:0] exp_order;
        tbl[0]  = v(4'b1000, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
        tbl[1]  = v(4'b1000, 0, 0, 0, 0, 6'b110001, 0, 0, 0);
        tbl[2]  = v(4'b1000, 0, 0, 0, 0, 6'b110001, 0, 0, 0);
        tbl[3]  = v(4'b0000, 0, 0, 0, 0, 6'b100100, 0, 5, 0);
        tbl[4]  = v(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 5, 0);
        tbl[5]  = v(4'b0011, 0, 0, 4, 32'h12345678, 6'b000000, 0, 5, 0);
        tbl[6]  = v(4'b0011, 0, 0, 4, 32'h12345678, 6'b111000, 4, 5, 0);
        tbl[7]  = v(4'b0011, 0, 0, 4, 32'h12345678, 6'b111000, 4, 5, 0);
        tbl[8]  = v(4'b0000, 0, 0, 0, 0, 6'b100010, 0, 5, 0);
        tbl[9]  = v(4'b1000, 4, 0, 0, 0, 6'b000001, 0, 5, 0);
        tbl[10] = v(4'b1000, 4, 0, 0, 0, 6'b110001, 4, 5, 0);
        tbl[11] = v(4'b1000, 4, 0, 0, 0, 6'b110001, 4, 5, 0);
        tbl[12] = v(4'b0000, 0, 0, 0, 0, 6'b100100, 0, 32'h12345678, 0);
        tbl[13] = v(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h12345678, 0);
        tbl[14] = v(4'b1000, 0, 0, 0, 0, 6'b000001, 0, 32'h12345678, 0);
        tbl[15] = v(4'b1010, 0, 0, 4, 0, 6'b110001, 0, 32'h12345678, 0);
        tbl[16] = v(4'b1010, 0, 0, 4, 0, 6'b110001, 0, 32'h12345678, 0);
        tbl[17] = v(4'b0010, 0, 0, 4, 0, 6'b100100, 0, 5, 0);
        tbl[18] = v(4'b0010, 0, 0, 4, 0, 6'b000000, 0, 5, 0);
        tbl[19] = v(4'b0010, 0, 0, 4, 0, 6'b110000, 4, 5, 0);
        tbl[20] = v(4'b0010, 0, 0, 4, 0, 6'b110000, 4, 5, 0);
        tbl[21] = v(4'b0000, 0, 0, 0, 0, 6'b100010, 0, 5, 32'h12345678);
        tbl[22] = v(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 5, 32'h12345678);

        // reset values, stall passthrough during reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst flags", 32'({busy, m_en, m_we, c_ack, d_ack}), 0);
        chk("rst cpu_rdata", c_rdata, 0);
        chk("rst dbg_rdata", d_rdata, 0);
        c_req = 1'b1;
        #1 chk("rst stall", 32'(c_stall), 1);
        c_req = 1'b0;
        @(negedge clk) rst = 1'b0;

        // asynchronous reset in the middle of a write
        @(negedge clk) {c_req, c_we, c_addr, c_wdata} = {1'b1, 1'b1, 32'h10, 32'hDEADBEEF};
        @(negedge clk) #1;
        chk("wr busy en/we", 32'({busy, m_en, m_we}), 32'b111);
        chk("wr addr", m_addr, 32'h10);
        chk("wr data", m_wdata, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk("midrst flags", 32'({busy, m_en, m_we, c_ack}), 0);
        chk("midrst rdata", c_rdata, 0);
        chk("midrst stall", 32'(c_stall), 1);
        {c_req, c_we, c_addr, c_wdata} = '0;
        @(negedge clk) #1 chk("midrst no ack", 32'(c_ack), 0);
        rst = 1'b0;

        // cpu read, dbg write, cpu read-back, dbg waiting behind cpu
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            {c_req, c_we, d_req, d_we} = tbl[i].req;
            {c_addr, c_wdata, d_addr, d_wdata} = {tbl[i].ca, tbl[i].cd, tbl[i].da, tbl[i].dd};
            #1;
            chk($sformatf("vec%0d flags", i), 32'({busy, m_en, m_we, c_ack, d_ack, c_stall}), 32'(tbl[i].flg));
            chk($sformatf("vec%0d mem_addr", i), m_addr, tbl[i].maddr);
            chk($sformatf("vec%0d cpu_rdata", i), c_rdata, tbl[i].crd);
            chk($sformatf("vec%0d dbg_rdata", i), d_rdata, tbl[i].drd);
        end

        // contention: both ports hold requests
        {c_req, c_we, c_addr, d_req, d_we, d_addr} = {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4};
        ng = 0;
        for (int k = 0; k < 80 && ng < 10; k++) begin
            @(negedge clk) #1;
            if (c_ack) grants[ng++] = 0;
            else if (d_ack) grants[ng++] = 1;
            if (d_ack) chk("contend dbg_rdata", d_rdata, 32'h12345678);
        end
        {c_req, d_req} = 2'b00;
        chk("contend grant count", ng, 10);
        exp_order = 10'b0000100001;
        for (int g = 0; g < ng; g++) chk($sformatf("grant%0d owner", g), grants[g], 32'(exp_order[9-g]));

        // back-to-back cpu accesses with the request held through DONE
        @(negedge clk) c_req = 1'b1;
        ng = 0;
        for (int k = 0; k < 40 && ng < 2; k++) begin
            @(negedge clk) #1;
            if (c_ack) at[ng++] = k;
        end
        c_req = 1'b0;
        chk("b2b ack count", ng, 2);
        if (ng == 2) chk("b2b ack spacing", at[1] - at[0], 4);

        // request dropped mid-transaction still completes once
        @(negedge clk) c_req = 1'b1;
        @(negedge clk) c_req = 1'b0;
        ng = 0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk) #1;
            if (c_ack) begin
                ng++;
                chk("drop ack cycle", k, 2);
            end
        end
        chk("drop ack count", ng, 1);

        // LATENCY=1 instance
        @(negedge clk) {r1, a1} = {1'b1, 32'h0};
        #1 chk("l1 c0", 32'({busy1, en1, ack1, stall1}), 32'b0001);
        @(negedge clk) #1 chk("l1 c1", 32'({busy1, en1, we1, ack1, stall1}), 32'b11001);
        r1 = 1'b0;
        @(negedge clk) #1 chk("l1 c2", 32'({busy1, en1, ack1, dack1}), 32'b1010);
        chk("l1 rdata", rd1, 5);
        @(negedge clk) #1 chk("l1 c3", 32'({busy1, en1, ack1}), 0);
        chk("l1 idle bus", ma1 | mwd1 | drd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
